req_encoder: RTL and testbench



---
 rtl/req_encoder_if.sv | 25 ++
 rtl/req_encoder.sv | 148 ++++++++++++++
 tb/tb_req_encoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/req_encoder_if.sv
// Request/code bundle between event sources and the req_encoder.
// The master side drives strobes and ready; the encoder (slave) returns code, valid, pend and ovf.
interface req_encoder_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = $clog2(N);

  logic [N-1:0] I;
  logic         ready;
  logic         clr_ovf;
  logic [W-1:0] Y;
  logic         valid;
  logic [N-1:0] pend;
  logic         ovf;

  modport master (
    output I, ready, clr_ovf,
    input  Y, valid, pend, ovf
  );

  modport slave (
    input  I, ready, clr_ovf,
    output Y, valid, pend, ovf
  );
endinterface

// File: rtl/req_encoder.sv
// Sequential N-to-log2(N) request encoder: latches event strobes into a pending register and
// serves one pending index at a time over valid/ready. Optional macro: ENC_ROUND_ROBIN_EN.
module req_encoder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  req_encoder_if.slave bus
);
  localparam int unsigned W = $clog2(N);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t       state;
  logic [N-1:0] p_q;
  logic [W-1:0] y_q;
  logic         valid_q;
  logic         ovf_q;

  logic         accept_c;
  logic [N-1:0] y_onehot_c;
  logic [N-1:0] clr_mask_c;
  logic [N-1:0] rest_c;
  logic [N-1:0] p_next_c;
  logic         ovf_set_c;
  logic [W-1:0] sel_first_c;
  logic [W-1:0] sel_next_c;

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr;

  // First set bit at or above start, wrapping; N is a power of two so W-bit addition wraps mod N.
  function automatic logic [W-1:0] sel(input logic [N-1:0] v, input logic [W-1:0] start);
    logic [W-1:0] idx;
    logic         found;
    logic [W-1:0] res;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      idx = W'(start + W'(k));
      if (!found && v[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    sel_first_c = sel(p_q, ptr);
    sel_next_c  = sel(rest_c, W'(y_q + W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept_c) begin
      ptr <= W'(y_q + W'(1));
    end
  end
`else
  // Fixed priority: lowest set index wins.
  function automatic logic [W-1:0] sel(input logic [N-1:0] v);
    logic [W-1:0] res;
    res = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (v[i]) res = W'(i);
    end
    return res;
  endfunction

  always_comb begin
    sel_first_c = sel(p_q);
    sel_next_c  = sel(rest_c);
  end
`endif

  // Accept/clear bookkeeping; a strobe on a line being cleared keeps it pending without overflow.
  always_comb begin
    accept_c   = valid_q & bus.ready;
    y_onehot_c = N'(1) << y_q;
    clr_mask_c = accept_c ? y_onehot_c : '0;
    rest_c     = p_q & ~y_onehot_c;
    p_next_c   = (p_q & ~clr_mask_c) | bus.I;
    ovf_set_c  = |(bus.I & p_q & ~clr_mask_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      p_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      p_q <= p_next_c;

      if (ovf_set_c) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end

      // Strobes from the accept cycle are not in rest_c; IDLE picks them up next cycle.
      case (state)
        IDLE: begin
          if (|p_q) begin
            y_q     <= sel_first_c;
            valid_q <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (accept_c) begin
            if (|rest_c) begin
              y_q <= sel_next_c;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.Y     = y_q;
  assign bus.valid = valid_q;
  assign bus.pend  = p_q;
  assign bus.ovf   = ovf_q;

`ifndef SYNTHESIS
  // Handshake stability: a presented code is held until it is accepted.
  hold_under_backpressure: assert property (
    @(posedge clk) disable iff (!rst_n)
    (valid_q && !bus.ready) |=> (valid_q && $stable(y_q))
  );

  presented_is_pending: assert property (
    @(posedge clk) disable iff (!rst_n)
    valid_q |-> p_q[y_q]
  );
`endif
endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: table of single-pulse vectors plus hand sequences for backpressure,
// overflow, full and reset corners; accepted codes are checked against a queue of expected codes.
module tb_req_encoder;
  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef struct {
    logic [7:0]  req;
    int          n;
    logic [31:0] codes;  // expected codes in order, first in the lowest nibble
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  req_encoder_if #(.N(N)) bus();

  req_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];
  vec_t         vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_codes(input int n, input logic [31:0] codes);
    for (int j = 0; j < n; j++) exp_q.push_back(W'(codes >> (4 * j)));
  endtask

  // Called at a negedge: drive inputs, score an accept on the coming edge, move to the next negedge.
  task automatic tick(input logic [7:0] req, input logic rdy, input logic clr);
    bus.I       = req;
    bus.ready   = rdy;
    bus.clr_ovf = clr;
    if (bus.valid && rdy) begin
      if (exp_q.size() == 0) check("unexpected_accept", 32'(bus.Y), 32'hFFFF_FFFF);
      else                   check("code", 32'(bus.Y), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && bus.valid; k++) tick(8'h00, 1'b1, 1'b0);
    check({name, "_drained"}, 32'(bus.valid), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_pend_clear"}, 32'(bus.pend), 32'd0);
  endtask

  logic [W-1:0] bp_first;
  logic [W-1:0] bp_second;

  initial begin
`ifdef ENC_ROUND_ROBIN_EN
    vecs[0] = '{8'h20, 1, 32'h0000_0005};
    vecs[1] = '{8'h40, 1, 32'h0000_0006};
    vecs[2] = '{8'h96, 4, 32'h0000_4217};
    vecs[3] = '{8'h01, 1, 32'h0000_0000};
    vecs[4] = '{8'h58, 3, 32'h0000_0643};
    vecs[5] = '{8'hFF, 8, 32'h6543_2107};
    vecs[6] = '{8'h81, 2, 32'h0000_0007};
    bp_first  = 3'd3;
    bp_second = 3'd0;
`else
    vecs[0] = '{8'h20, 1, 32'h0000_0005};
    vecs[1] = '{8'h40, 1, 32'h0000_0006};
    vecs[2] = '{8'h96, 4, 32'h0000_7421};
    vecs[3] = '{8'h01, 1, 32'h0000_0000};
    vecs[4] = '{8'h58, 3, 32'h0000_0643};
    vecs[5] = '{8'hFF, 8, 32'h7654_3210};
    vecs[6] = '{8'h81, 2, 32'h0000_0070};
    bp_first  = 3'd0;
    bp_second = 3'd3;
`endif

    // Reset with all strobes high, release with strobes low.
    rst_n       = 1'b0;
    bus.I       = 8'hFF;
    bus.ready   = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pend_held", 32'(bus.pend), 32'd0);
    rst_n = 1'b1;
    bus.I = 8'h00;
    @(negedge clk);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_Y", 32'(bus.Y), 32'd0);
    check("reset_pend", 32'(bus.pend), 32'd0);
    check("reset_ovf", 32'(bus.ovf), 32'd0);
    tick(8'h00, 1'b1, 1'b0);
    check("empty_valid", 32'(bus.valid), 32'd0);

    // Single pulses from IDLE with ready high.
    foreach (vecs[v]) begin
      push_codes(vecs[v].n, vecs[v].codes);
      tick(vecs[v].req, 1'b1, 1'b0);
      check("pend_after_strobe", 32'(bus.pend), 32'(vecs[v].req));
      check("valid_latency_lo", 32'(bus.valid), 32'd0);
      tick(8'h00, 1'b1, 1'b0);
      check("valid_latency_hi", 32'(bus.valid), 32'd1);
      drain("vec");
    end

    // Backpressure: code held stable while ready is low.
    exp_q.push_back(bp_first);
    exp_q.push_back(bp_second);
    tick(8'h09, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(bus.valid), 32'd1);
      check("bp_Y", 32'(bus.Y), 32'(bp_first));
      tick(8'h00, 1'b0, 1'b0);
    end
    drain("bp");

    // Overflow, clear-vs-set, and set-wins on the accept cycle.
    tick(8'h08, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0);
    check("ovf_present_valid", 32'(bus.valid), 32'd1);
    check("ovf_present_Y", 32'(bus.Y), 32'd3);
    check("ovf_initial", 32'(bus.ovf), 32'd0);
    tick(8'h08, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.ovf), 32'd1);
    tick(8'h08, 1'b0, 1'b1);
    check("ovf_set_beats_clear", 32'(bus.ovf), 32'd1);
    tick(8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(bus.ovf), 32'd0);
    exp_q.push_back(3'd3);
    tick(8'h08, 1'b1, 1'b0);
    check("setwin_pend", 32'(bus.pend), 32'h08);
    check("setwin_no_ovf", 32'(bus.ovf), 32'd0);
    check("setwin_valid_drop", 32'(bus.valid), 32'd0);
    exp_q.push_back(3'd3);
    tick(8'h00, 1'b1, 1'b0);
    check("setwin_represent_valid", 32'(bus.valid), 32'd1);
    check("setwin_represent_Y", 32'(bus.Y), 32'd3);
    drain("setwin");

    // Full pending register: overflow on every line, then served one per accept.
    tick(8'hFF, 1'b0, 1'b0);
    check("full_ovf_first", 32'(bus.ovf), 32'd0);
    tick(8'hFF, 1'b0, 1'b0);
    check("full_pend", 32'(bus.pend), 32'hFF);
    check("full_ovf", 32'(bus.ovf), 32'd1);
    tick(8'h00, 1'b0, 1'b1);
    check("full_ovf_clear", 32'(bus.ovf), 32'd0);
`ifdef ENC_ROUND_ROBIN_EN
    push_codes(8, 32'h3210_7654);
`else
    push_codes(8, 32'h7654_3210);
`endif
    drain("full");

    // Asynchronous reset while presenting discards pending events.
    tick(8'h0C, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0);
    check("midrst_pre_valid", 32'(bus.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid_drop", 32'(bus.valid), 32'd0);
    check("midrst_pend_drop", 32'(bus.pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(8'h00, 1'b1, 1'b0);
      check("postrst_valid", 32'(bus.valid), 32'd0);
      check("postrst_pend", 32'(bus.pend), 32'd0);
    end
    check("postrst_Y", 32'(bus.Y), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
